// File: rtl/mdio_pkg.sv
// ---------------------------------------------------------------------------
// mdio_pkg
// Shared definitions for the MDIO management responder:
//   - state_t        : frame-parser state encoding
//   - OP_RD / OP_WR  : clause-22 opcodes
//   - ST_PATTERN     : start-of-frame pattern (first bit 0, second bit 1)
//   - DEFAULT_PRE_LEN: default minimum preamble length in MDC cycles
//   - SYNC_DEPTH     : flop depth of the MDC / MDIO input synchronizers
//   - op_valid()     : true for the two legal opcodes
// ---------------------------------------------------------------------------
package mdio_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_OP,
    S_PHYAD,
    S_REGAD,
    S_TA,
    S_WDATA,
    S_RDATA
  } state_t;

  localparam logic [1:0] OP_RD           = 2'b10;
  localparam logic [1:0] OP_WR           = 2'b01;
  localparam logic [1:0] ST_PATTERN      = 2'b01;
  localparam int         DEFAULT_PRE_LEN = 32;
  localparam int         SYNC_DEPTH      = 2;

  function automatic logic op_valid(input logic [1:0] op);
    return (op == OP_RD) || (op == OP_WR);
  endfunction

endpackage

// File: rtl/mdio_edge_sync.sv
// ---------------------------------------------------------------------------
// mdio_edge_sync
// Brings an asynchronous level (the station's MDC) into the clk domain
// through SYNC_DEPTH flops and flags its rising edges.
//   clk  : system clock
//   rst  : asynchronous active-high reset (all flops preset to 1)
//   din  : asynchronous input level
//   rise : one-clk pulse when the synchronized level goes 0 -> 1
// Presetting to 1 means a line that is low when reset is released never
// produces a false rising edge.
// ---------------------------------------------------------------------------
module mdio_edge_sync
  import mdio_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic [SYNC_DEPTH-1:0] sync_reg;
  logic                  prev_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg <= '1;
      prev_reg <= 1'b1;
    end else begin
      sync_reg <= {sync_reg[SYNC_DEPTH-2:0], din};
      prev_reg <= sync_reg[SYNC_DEPTH-1];
    end
  end

  assign rise = sync_reg[SYNC_DEPTH-1] & ~prev_reg;

endmodule

// File: rtl/mdio_slave.sv
// ---------------------------------------------------------------------------
// mdio_slave
// Clause-22 style MDIO management responder. MDC and MDIO are sampled in the
// clk domain (clk must run at least 8x MDC); every MDC rising edge advances
// the frame parser by one bit.
//   Parameters : PHY_ADDR (address answered to), PRE_LEN (min preamble ones)
//   clk, rst   : system clock, asynchronous active-high reset
//   eth_mdc    : management clock from the station (asynchronous)
//   mdio_in    : MDIO pad input
//   mdio_out   : MDIO pad output value (1 whenever not driving)
//   mdio_oe    : MDIO pad output enable (1 = drive, 0 = Z)
//   reg_addr   : register address of the current frame
//   reg_wr     : one-clk write strobe, reg_wr_data valid with it
//   reg_rd     : one-clk read strobe, reg_rd_data captured on the next clk
//   busy       : high from start-of-frame detection until back in IDLE
//   frame_err  : one-clk pulse on an illegal opcode
// ---------------------------------------------------------------------------
module mdio_slave
  import mdio_pkg::*;
#(
  parameter logic [4:0] PHY_ADDR = 5'b00111,
  parameter int         PRE_LEN  = DEFAULT_PRE_LEN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        eth_mdc,
  input  logic        mdio_in,
  output logic        mdio_out,
  output logic        mdio_oe,
  output logic [4:0]  reg_addr,
  output logic        reg_wr,
  output logic [15:0] reg_wr_data,
  output logic        reg_rd,
  input  logic [15:0] reg_rd_data,
  output logic        busy,
  output logic        frame_err
);

  localparam int              PRE_W   = $clog2(PRE_LEN + 1);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRE_LEN);

  // ---------------------------------------------------------------------
  // Input synchronization: MDC through the edge detector, MDIO through a
  // plain synchronizer of the same depth so both stay bit-aligned.
  // ---------------------------------------------------------------------
  logic                  mdc_rise;
  logic [SYNC_DEPTH-1:0] mdio_sync_reg;
  logic                  bit_in;

  mdio_edge_sync u_mdc_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (eth_mdc),
    .rise (mdc_rise)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mdio_sync_reg <= '1;
    end else begin
      mdio_sync_reg <= {mdio_sync_reg[SYNC_DEPTH-2:0], mdio_in};
    end
  end

  assign bit_in = mdio_sync_reg[SYNC_DEPTH-1];

  // ---------------------------------------------------------------------
  // Frame parser state
  // ---------------------------------------------------------------------
  state_t           state_reg;
  logic [4:0]       bit_cnt_reg;
  logic [PRE_W-1:0] pre_cnt_reg;
  logic             op_first_reg;   // first opcode bit, held until the second
  logic             is_read_reg;
  logic             phy_match_reg;
  logic [4:0]       addr_sh_reg;    // shared PHYAD / REGAD shifter
  logic [15:0]      data_sh_reg;    // write capture or read shift-out

  logic [1:0]  op_next;
  logic [4:0]  addr_next;
  logic [15:0] data_next;

  always_comb begin
    op_next   = {op_first_reg, bit_in};
    addr_next = {addr_sh_reg[3:0], bit_in};
    data_next = {data_sh_reg[14:0], bit_in};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      bit_cnt_reg   <= '0;
      pre_cnt_reg   <= '0;
      op_first_reg  <= 1'b0;
      is_read_reg   <= 1'b0;
      phy_match_reg <= 1'b0;
      addr_sh_reg   <= '0;
      data_sh_reg   <= '0;
      mdio_oe       <= 1'b0;
      mdio_out      <= 1'b1;
      reg_addr      <= '0;
      reg_wr        <= 1'b0;
      reg_wr_data   <= '0;
      reg_rd        <= 1'b0;
      busy          <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      reg_wr    <= 1'b0;
      reg_rd    <= 1'b0;
      frame_err <= 1'b0;

      // Read data is taken one clk after the strobe; the next MDC rise is
      // many clks away, so this never collides with the shifter below.
      if (reg_rd) begin
        data_sh_reg <= reg_rd_data;
      end

      if (mdc_rise) begin
        unique case (state_reg)
          S_IDLE: begin
            if (bit_in) begin
              if (pre_cnt_reg != PRE_MAX) begin
                pre_cnt_reg <= pre_cnt_reg + PRE_W'(1);
              end
            end else if (pre_cnt_reg == PRE_MAX) begin
              // This 0 is the first start bit after a full preamble.
              state_reg   <= S_START;
              busy        <= 1'b1;
              pre_cnt_reg <= '0;
            end else begin
              pre_cnt_reg <= '0;
            end
          end

          S_START: begin
            if (bit_in == ST_PATTERN[0]) begin
              state_reg   <= S_OP;
              bit_cnt_reg <= '0;
            end else begin
              state_reg   <= S_IDLE;
              busy        <= 1'b0;
              pre_cnt_reg <= '0;
            end
          end

          S_OP: begin
            if (bit_cnt_reg == 5'd0) begin
              op_first_reg <= bit_in;
              bit_cnt_reg  <= 5'd1;
            end else begin
              bit_cnt_reg <= '0;
              if (op_valid(op_next)) begin
                is_read_reg <= (op_next == OP_RD);
                state_reg   <= S_PHYAD;
              end else begin
                frame_err   <= 1'b1;
                state_reg   <= S_IDLE;
                busy        <= 1'b0;
                pre_cnt_reg <= '0;
              end
            end
          end

          S_PHYAD: begin
            addr_sh_reg <= addr_next;
            if (bit_cnt_reg == 5'd4) begin
              phy_match_reg <= (addr_next == PHY_ADDR);
              bit_cnt_reg   <= '0;
              state_reg     <= S_REGAD;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 5'd1;
            end
          end

          S_REGAD: begin
            addr_sh_reg <= addr_next;
            if (bit_cnt_reg == 5'd4) begin
              reg_addr    <= addr_next;
              reg_rd      <= is_read_reg & phy_match_reg;
              bit_cnt_reg <= '0;
              state_reg   <= S_TA;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 5'd1;
            end
          end

          S_TA: begin
            if (is_read_reg) begin
              // The rise closing the first TA bit: start driving the
              // second TA bit as 0 (only when addressed).
              if (phy_match_reg) begin
                mdio_oe  <= 1'b1;
                mdio_out <= 1'b0;
              end
              bit_cnt_reg <= '0;
              state_reg   <= S_RDATA;
            end else if (bit_cnt_reg == 5'd1) begin
              bit_cnt_reg <= '0;
              state_reg   <= S_WDATA;
            end else begin
              bit_cnt_reg <= 5'd1;
            end
          end

          S_WDATA: begin
            data_sh_reg <= data_next;
            if (bit_cnt_reg == 5'd15) begin
              if (phy_match_reg) begin
                reg_wr      <= 1'b1;
                reg_wr_data <= data_next;
              end
              bit_cnt_reg <= '0;
              state_reg   <= S_IDLE;
              busy        <= 1'b0;
              pre_cnt_reg <= '0;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 5'd1;
            end
          end

          S_RDATA: begin
            // Rises 0..15 put D15..D0 on the line; rise 16 releases it.
            if (bit_cnt_reg == 5'd16) begin
              mdio_oe     <= 1'b0;
              mdio_out    <= 1'b1;
              bit_cnt_reg <= '0;
              state_reg   <= S_IDLE;
              busy        <= 1'b0;
              pre_cnt_reg <= '0;
            end else begin
              if (phy_match_reg) begin
                mdio_out <= data_sh_reg[15];
              end
              data_sh_reg <= {data_sh_reg[14:0], 1'b0};
              bit_cnt_reg <= bit_cnt_reg + 5'd1;
            end
          end

          default: begin
            state_reg   <= S_IDLE;
            busy        <= 1'b0;
            pre_cnt_reg <= '0;
            mdio_oe     <= 1'b0;
            mdio_out    <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/mdio_slave.md
MDIO_SLAVE -- requirements
Module: mdio_slave

Interface
REQ-001 Parameter PHY_ADDR, default 5'b00111, the PHY address this responder answers to.
REQ-002 Parameter PRE_LEN, default 32, the minimum number of consecutive preamble ones.
REQ-003 Port clk, input, 1, system clock; one clock only.
REQ-004 Port rst, input, 1, reset; asynchronous and active-high.
REQ-005 Port eth_mdc, input, 1, management clock from the station; asynchronous to clk.
REQ-006 Port mdio_in, input, 1, MDIO pad input.
REQ-007 Port mdio_out, output, 1, MDIO pad output value.
REQ-008 Port mdio_oe, output, 1, MDIO pad output enable; 1 means drive, 0 means Z.
REQ-009 Port reg_addr, output, 5, register address of the current frame.
REQ-010 Port reg_wr, output, 1, one-clk write strobe.
REQ-011 Port reg_wr_data, output, 16, write data; valid while reg_wr is 1.
REQ-012 Port reg_rd, output, 1, one-clk read strobe; reg_rd_data is captured on the next clk.
REQ-013 Port reg_rd_data, input, 16, register read value from user logic.
REQ-014 Port busy, output, 1, high from ST detection until the frame ends or is aborted.
REQ-015 Port frame_err, output, 1, one-clk pulse on an illegal opcode.

Function
REQ-016 The block SHALL synchronize eth_mdc and mdio_in through 2 flops each; an MDC rising edge (rise) is sync_mdc equal to 1 while its previous value was 0.
REQ-017 The block SHALL sample the synchronized mdio on rise only; the clk frequency SHALL be at least 8 times the MDC frequency.
REQ-018 States: IDLE, START, OP, PHYAD, REGAD, TA, WDATA, RDATA; a 5-bit bit counter and a preamble counter saturating at PRE_LEN.
REQ-019 IDLE: count ones, clearing the count on a 0; a 0 with count equal to PRE_LEN goes to START; a 0 with count below PRE_LEN stays in IDLE.
REQ-020 START: a 1 goes to OP; a 0 goes to IDLE.
REQ-021 OP: capture 2 bits; 10 means read, 01 means write; 00 or 11 pulses frame_err and goes to IDLE.
REQ-022 PHYAD then REGAD: capture 5 bits each, MSB first.
REQ-023 reg_addr SHALL update when the last REGAD bit is captured.
REQ-024 A PHYAD mismatch SHALL complete the frame silently: no strobe and mdio_oe held at 0.
REQ-025 Read with an address match: pulse reg_rd 1 clk after the last REGAD rise, then latch reg_rd_data the next clk.
REQ-026 Read TA, first bit: mdio_oe stays 0.
REQ-027 Read TA, second bit: on the rise ending TA bit 1, drive mdio_oe to 1 and mdio_out to 0 within 3 clk.
REQ-028 Read data: on each following rise, shift out D15..D0, each driven within 3 clk of the rise.
REQ-029 Read end: on the rise after D0 is driven, set mdio_oe to 0 and go to IDLE.
REQ-030 Write TA: the 2 TA bits are captured and not checked.
REQ-031 Write data: WDATA captures 16 bits MSB first.
REQ-032 Write end: after the 16th rise with an address match, pulse reg_wr for 1 clk with reg_wr_data valid, then go to IDLE.
REQ-033 The preamble count SHALL clear on every entry to IDLE; each frame requires a fresh preamble.
REQ-034 mdio_oe SHALL be 1 only in the read TA second bit and RDATA; mdio_out SHALL be 1 when not driving.
REQ-035 The block SHALL drive nothing while mdio_oe is 0.
REQ-036 busy SHALL be 1 from START through the return to IDLE.

Reset
REQ-037 rst SHALL asynchronously force: state IDLE, all counters 0, mdio_oe 0, mdio_out 1, reg_wr 0, reg_rd 0, frame_err 0, busy 0, reg_addr 0, reg_wr_data 0, and the synchronizers to 1.
REQ-038 A reset mid-frame SHALL abort the frame with no strobe; the next frame requires a full preamble.

Structure
REQ-039 Package mdio_pkg SHALL hold: the state encoding, OP_RD (2'b10), OP_WR (2'b01), the ST pattern (2'b01), and the default PRE_LEN.
REQ-040 Sub-module mdio_edge_sync (2-flop synchronizer plus rise detect) SHALL be instantiated for eth_mdc; mdio_in SHALL use the same synchronizer depth.

Verification
REQ-041 Write: 32 ones, then ST 01, OP 01, PHYAD 00111, REGAD 00000, TA 10, data 0x1140 -> one reg_wr pulse with reg_addr 0 and reg_wr_data 0x1140; mdio_oe stays 0 throughout.
REQ-042 Read: same header with OP 10, REGAD 00001, reg_rd_data 0x796D -> one reg_rd pulse; the master samples Z then 0 in TA, then 0x796D on 16 MDC rises; mdio_oe is 0 after D0.
REQ-043 Address mismatch: read to PHYAD 00011 -> no reg_rd pulse, no reg_wr pulse, mdio_oe is 0 for the whole frame.
REQ-044 Short preamble (31 ones) then a valid write -> no reg_wr pulse; an immediately following frame with 32 ones is accepted.
REQ-045 Illegal OP 11 -> frame_err pulses once, no strobe; the next valid read returns correct data.
REQ-046 rst asserted during RDATA at bit D8 -> mdio_oe goes to 0 asynchronously, no further drive occurs, and the next valid frame completes normally.
